// File: rtl/common_pkg.sv
// Shared array geometry, operand data type and feeder state encoding.
package common_pkg;

  localparam int unsigned SYS_ARRAY_SIZE     = 4;
  localparam int unsigned DRAIN_CHANNEL_SIZE = 4;
  localparam int unsigned DATA_W             = 16;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_FLUSH,
    ST_DRAIN
  } feeder_state_t;

endpackage

// File: rtl/operand_buffer.sv
// Tile operand store: one write port, one write-first synchronous read port.
// The read register clears whenever no read is issued.
module operand_buffer
  import common_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             wr_en_i,
  input  logic [AW-1:0]                    wr_addr_i,
  input  data_t [SYS_ARRAY_SIZE-1:0]       wr_a_i,
  input  data_t [SYS_ARRAY_SIZE-1:0]       wr_b_i,
  input  logic                             rd_en_i,
  input  logic [AW-1:0]                    rd_addr_i,
  output data_t [SYS_ARRAY_SIZE-1:0]       rd_a_o,
  output data_t [SYS_ARRAY_SIZE-1:0]       rd_b_o
);

  localparam int unsigned EW = 2 * SYS_ARRAY_SIZE * DATA_W;

  typedef logic [EW-1:0] entry_t;

  entry_t mem [DEPTH];
  entry_t rd_q;

  // Storage is intentionally not reset; only the feeder's counters are.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= {wr_a_i, wr_b_i};
    end
  end

  // Same-address write bypass covers the single-pair tile sealed and read on one edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q <= '0;
    end else if (!rd_en_i) begin
      rd_q <= '0;
    end else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      rd_q <= {wr_a_i, wr_b_i};
    end else begin
      rd_q <= mem[rd_addr_i];
    end
  end

  assign {rd_a_o, rd_b_o} = rd_q;

endmodule

// File: rtl/operand_feeder.sv
// Collects one tile of operand pairs, streams them bubble-free to the array,
// then waits out the pipeline flush and pulses the drain control.
module operand_feeder
  import common_pkg::*;
#(
  parameter int unsigned MAX_K        = 16,
  parameter int unsigned FLUSH_CYCLES = 2 * SYS_ARRAY_SIZE,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CHANNEL_SIZE
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  data_t [SYS_ARRAY_SIZE-1:0]  in_a_i,
  input  data_t [SYS_ARRAY_SIZE-1:0]  in_b_i,
  input  logic                        in_last_i,
  output data_t [SYS_ARRAY_SIZE-1:0]  a_o,
  output data_t [SYS_ARRAY_SIZE-1:0]  b_o,
  output logic                        last_o,
  output logic                        ctrl_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        ovf_o
);

  localparam int unsigned KW = $clog2(MAX_K + 1);
  localparam int unsigned AW = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [KW-1:0] K_CAP  = KW'(MAX_K - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYCLES - 1);

  feeder_state_t   state;
  logic [KW-1:0]   wr_ptr;
  logic [KW-1:0]   rd_ptr;
  logic [FW-1:0]   flush_cnt;
  logic [DW-1:0]   drain_cnt;
  logic            accept_q;
  logic            last_q;
  logic            busy_q;
  logic            ctrl_q;
  logic            done_q;

  logic            xfer;
  logic            at_cap;
  logic            seal;
  logic            stream_more;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;

  assign in_ready_o  = accept_q & ~rst_i;
  assign xfer        = in_valid_i & in_ready_o;
  assign at_cap      = (wr_ptr == K_CAP);
  assign seal        = xfer & (in_last_i | at_cap);
  assign ovf_o       = xfer & at_cap & ~in_last_i;

  // Entry 0 is fetched on the sealing edge so it appears in the first STREAM cycle.
  assign stream_more = (state == ST_STREAM) && (rd_ptr != wr_ptr);
  assign rd_en       = seal | stream_more;
  assign rd_addr     = stream_more ? AW'(rd_ptr) : '0;

  operand_buffer #(
    .DEPTH (MAX_K),
    .AW    (AW)
  ) u_buffer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (xfer),
    .wr_addr_i (AW'(wr_ptr)),
    .wr_a_i    (in_a_i),
    .wr_b_i    (in_b_i),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_a_o    (a_o),
    .rd_b_o    (b_o)
  );

  // rd_ptr always names the next entry to fetch; wr_ptr doubles as the tile length.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      flush_cnt <= '0;
      drain_cnt <= '0;
      accept_q  <= 1'b1;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      ctrl_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE, ST_LOAD: begin
          if (xfer) begin
            wr_ptr <= wr_ptr + KW'(1);
            busy_q <= 1'b1;
            if (seal) begin
              state    <= ST_STREAM;
              accept_q <= 1'b0;
              rd_ptr   <= KW'(1);
              last_q   <= (wr_ptr == '0);
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_STREAM: begin
          if (rd_ptr == wr_ptr) begin
            state     <= ST_FLUSH;
            last_q    <= 1'b0;
            flush_cnt <= '0;
          end else begin
            rd_ptr <= rd_ptr + KW'(1);
            last_q <= ((rd_ptr + KW'(1)) == wr_ptr);
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == F_LAST) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
            ctrl_q    <= 1'b1;
            done_q    <= (DRAIN_CYCLES == 1);
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == D_LAST) begin
            state    <= ST_IDLE;
            ctrl_q   <= 1'b0;
            busy_q   <= 1'b0;
            accept_q <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
            done_q    <= ((drain_cnt + DW'(1)) == D_LAST);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign last_o = last_q;
  assign ctrl_o = ctrl_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_operand_feeder.sv
// Randomized self-checking bench for operand_feeder against a queue-based tile model.
module tb_operand_feeder;
  import common_pkg::*;

  localparam int MAX_K = 16;
  localparam int FLUSH = 8;
  localparam int DRAIN = 4;

  typedef data_t [SYS_ARRAY_SIZE-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready_o;
  vec_t in_a;
  vec_t in_b;
  logic in_last;
  vec_t a_o;
  vec_t b_o;
  logic last_o;
  logic ctrl_o;
  logic busy_o;
  logic done_o;
  logic ovf_o;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t q_a[$];
  vec_t q_b[$];
  vec_t hold_a;
  vec_t hold_b;
  bit   hold_last;

  operand_feeder #(
    .MAX_K        (MAX_K),
    .FLUSH_CYCLES (FLUSH),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready_o),
    .in_a_i     (in_a),
    .in_b_i     (in_b),
    .in_last_i  (in_last),
    .a_o        (a_o),
    .b_o        (b_o),
    .last_o     (last_o),
    .ctrl_o     (ctrl_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < SYS_ARRAY_SIZE; i++) v[i] = data_t'($urandom);
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Offers up to n pairs while the feeder should be accepting; returns the sealed tile length.
  task automatic feed(input int n, input bit with_last, input int valid_pct,
                      input bit fixed, input bit use_hold, output int k);
    int  sent = 0;
    int  guard = 0;
    bit  sealed = 0;
    bit  exp_ovf;
    k = 0;
    while (!sealed && sent < n) begin
      next_cycle();
      in_valid = (use_hold && sent == 0) || ($urandom_range(99) < valid_pct);
      if (use_hold && sent == 0) begin
        in_a = hold_a; in_b = hold_b; in_last = hold_last;
      end else if (fixed) begin
        for (int i = 0; i < SYS_ARRAY_SIZE; i++) begin
          in_a[i] = data_t'(sent + 1);
          in_b[i] = data_t'(10 * (sent + 1));
        end
        in_last = with_last && (sent == n - 1);
      end else begin
        in_a = rand_vec(); in_b = rand_vec();
        in_last = with_last && (sent == n - 1);
      end
      #1;
      exp_ovf = in_valid && !in_last && (k == MAX_K - 1);
      n_checks++;
      if (in_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL feed_ready pair %0d: got %b expected 1", sent, in_ready_o);
      end
      n_checks++;
      if (busy_o !== (k > 0)) begin
        n_fail++; $display("FAIL feed_busy pair %0d: got %b expected %b", sent, busy_o, k > 0);
      end
      n_checks++;
      if (ovf_o !== exp_ovf) begin
        n_fail++; $display("FAIL feed_ovf pair %0d: got %b expected %b", sent, ovf_o, exp_ovf);
      end
      n_checks++;
      if (a_o !== '0 || b_o !== '0 || last_o !== 1'b0 || ctrl_o !== 1'b0 || done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL feed_quiet pair %0d: got a=%h last=%b ctrl=%b done=%b expected all 0",
                 sent, a_o, last_o, ctrl_o, done_o);
      end
      if (in_valid) begin
        q_a.push_back(in_a);
        q_b.push_back(in_b);
        k++;
        sent++;
        sealed = in_last || (k == MAX_K);
      end
      guard++;
      if (guard > 2000) begin
        n_fail++; $display("FAIL feed_timeout: got %0d pairs expected %0d", sent, n);
        break;
      end
    end
  endtask

  // Walks stream, flush and drain of a sealed k-pair tile; optionally holds a pending pair.
  task automatic stream_check(input int k, input bit hold);
    vec_t ea;
    vec_t eb;
    for (int c = 0; c < k + FLUSH + DRAIN; c++) begin
      next_cycle();
      in_valid = hold;
      if (hold) begin
        in_a = hold_a; in_b = hold_b; in_last = hold_last;
      end
      #1;
      if (c < k && q_a.size() > 0) begin
        ea = q_a.pop_front(); eb = q_b.pop_front();
      end else begin
        ea = '0; eb = '0;
      end
      n_checks++;
      if (a_o !== ea || b_o !== eb) begin
        n_fail++; $display("FAIL stream_data c%0d: got a=%h b=%h expected a=%h b=%h", c, a_o, b_o, ea, eb);
      end
      n_checks++;
      if (last_o !== (c == k - 1)) begin
        n_fail++; $display("FAIL stream_last c%0d: got %b expected %b", c, last_o, c == k - 1);
      end
      n_checks++;
      if (ctrl_o !== (c >= k + FLUSH)) begin
        n_fail++; $display("FAIL drain_ctrl c%0d: got %b expected %b", c, ctrl_o, c >= k + FLUSH);
      end
      n_checks++;
      if (done_o !== (c == k + FLUSH + DRAIN - 1)) begin
        n_fail++; $display("FAIL drain_done c%0d: got %b expected %b", c, done_o, c == k + FLUSH + DRAIN - 1);
      end
      n_checks++;
      if (busy_o !== 1'b1 || in_ready_o !== 1'b0 || ovf_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_ctl c%0d: got busy=%b ready=%b ovf=%b expected 1 0 0", c, busy_o, in_ready_o, ovf_o);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_a = rand_vec(); in_b = rand_vec(); in_last = 1'b1;
    repeat (2) next_cycle();
    #1;
    n_checks++;
    if (in_ready_o !== 1'b0 || busy_o !== 1'b0 || ovf_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl: got ready=%b busy=%b ovf=%b expected 0 0 0", in_ready_o, busy_o, ovf_o);
    end
    n_checks++;
    if (a_o !== '0 || b_o !== '0 || last_o !== 1'b0 || ctrl_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_data: got a=%h b=%h last=%b ctrl=%b done=%b expected 0", a_o, b_o, last_o, ctrl_o, done_o);
    end
    next_cycle();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got ready=%b busy=%b expected 1 0", in_ready_o, busy_o);
    end
  endtask

  task automatic test_basic();
    int k;
    feed(3, 1'b1, 100, 1'b1, 1'b0, k);
    stream_check(k, 1'b0);
  endtask

  task automatic test_single();
    int k;
    feed(1, 1'b1, 100, 1'b0, 1'b0, k);
    stream_check(k, 1'b0);
  endtask

  task automatic test_overflow();
    int k;
    feed(MAX_K + 1, 1'b0, 100, 1'b0, 1'b0, k);
    hold_a = rand_vec(); hold_b = rand_vec(); hold_last = 1'b0;
    stream_check(k, 1'b1);
    feed(3, 1'b1, 100, 1'b0, 1'b1, k);
    stream_check(k, 1'b0);
  endtask

  task automatic test_random_valid();
    int k;
    for (int t = 0; t < 4; t++) begin
      feed(int'($urandom_range(12, 2)), 1'b1, 45, 1'b0, 1'b0, k);
      stream_check(k, 1'b0);
    end
  endtask

  task automatic test_reset_mid_stream();
    int   k;
    vec_t ea;
    vec_t eb;
    feed(5, 1'b1, 100, 1'b0, 1'b0, k);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      in_valid = 1'b0;
      if (c == 2) rst = 1'b1;
      #1;
      ea = q_a.pop_front(); eb = q_b.pop_front();
      n_checks++;
      if (a_o !== ea || b_o !== eb || busy_o !== 1'b1 || in_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_stream c%0d: got a=%h b=%h busy=%b ready=%b expected a=%h b=%h 1 0",
                 c, a_o, b_o, busy_o, in_ready_o, ea, eb);
      end
    end
    next_cycle();
    rst = 1'b0;
    #1;
    q_a.delete(); q_b.delete();
    n_checks++;
    if (a_o !== '0 || b_o !== '0 || last_o !== 1'b0 || ctrl_o !== 1'b0 || busy_o !== 1'b0 ||
        done_o !== 1'b0 || ovf_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_after: got a=%h b=%h last=%b ctrl=%b busy=%b done=%b ready=%b expected zeros ready=1",
               a_o, b_o, last_o, ctrl_o, busy_o, done_o, in_ready_o);
    end
    feed(2, 1'b1, 100, 1'b0, 1'b0, k);
    stream_check(k, 1'b0);
  endtask

  task automatic test_hold_in_drain();
    int k;
    feed(2, 1'b1, 100, 1'b0, 1'b0, k);
    hold_a = rand_vec(); hold_b = rand_vec(); hold_last = 1'b1;
    stream_check(k, 1'b1);
    feed(1, 1'b1, 100, 1'b0, 1'b1, k);
    stream_check(k, 1'b0);
    next_cycle();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL final_idle: got busy=%b ready=%b expected 0 1", busy_o, in_ready_o);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    test_reset();
    test_basic();
    test_single();
    test_overflow();
    test_random_valid();
    test_reset_mid_stream();
    test_hold_in_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_feeder.md
OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 Parameter MAX_K, default 16, is the maximum number of operand vector pairs per tile (buffer depth).
REQ-002 Parameter FLUSH_CYCLES, default 2*SYS_ARRAY_SIZE, is the idle cycles between last_o and the first ctrl_o.
REQ-003 Parameter DRAIN_CYCLES, default DRAIN_CHANNEL_SIZE, is the number of consecutive cycles ctrl_o is held high.
REQ-004 clk_i  input  1  single clock; all logic rising-edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 in_valid_i  input  1  upstream pair valid.
REQ-007 in_ready_o  output  1  feeder can accept a pair.
REQ-008 in_a_i  input  data_t[SYS_ARRAY_SIZE]  A-side operand vector.
REQ-009 in_b_i  input  data_t[SYS_ARRAY_SIZE]  B-side operand vector.
REQ-010 in_last_i  input  1  marks final pair of a tile.
REQ-011 a_o  output  data_t[SYS_ARRAY_SIZE]  A vector to the array wrapper.
REQ-012 b_o  output  data_t[SYS_ARRAY_SIZE]  B vector to the array wrapper.
REQ-013 last_o  output  1  high with the final streamed pair.
REQ-014 ctrl_o  output  1  drain-control to the array wrapper.
REQ-015 busy_o  output  1  high in any state other than IDLE.
REQ-016 done_o  output  1  one-cycle pulse on the last DRAIN cycle.
REQ-017 ovf_o  output  1  one-cycle pulse when a tile is truncated at MAX_K.

Function
REQ-018 FSM states IDLE, LOAD, STREAM, FLUSH, DRAIN; IDLE->LOAD on first accepted pair, or directly to STREAM if that pair has in_last_i=1.
REQ-019 Transfer occurs when in_valid_i && in_ready_o; in_ready_o=1 only in IDLE and LOAD.
REQ-020 Accepted pairs are written to the buffer at a write pointer starting at 0; count k = pairs accepted.
REQ-021 LOAD->STREAM on the cycle after accepting a pair with in_last_i=1, or after accepting the MAX_K-th pair; in the latter case with in_last_i=0, ovf_o pulses on that acceptance cycle.
REQ-022 STREAM presents buffer entries 0..k-1 on a_o/b_o on k consecutive cycles with no bubbles; a_o/b_o are registered outputs.
REQ-023 last_o=1 exactly in the cycle entry k-1 is presented, including k=1.
REQ-024 Outside STREAM, a_o, b_o, last_o are all zero.
REQ-025 FLUSH counts exactly FLUSH_CYCLES cycles after the last STREAM cycle, then enters DRAIN.
REQ-026 DRAIN holds ctrl_o=1 for exactly DRAIN_CYCLES cycles; done_o=1 on the final one; next state is IDLE.
REQ-027 ctrl_o=0 in all other states.
REQ-028 Upstream valid during STREAM/FLUSH/DRAIN is back-pressured (in_ready_o=0) and not lost; the pair must remain held by upstream per valid/ready rules.
REQ-029 Counters are sized clog2(MAX_K+1), clog2(FLUSH_CYCLES+1), clog2(DRAIN_CYCLES+1); no wrap occurs within a tile.

Reset
REQ-030 rst_i=1 at any time, including mid-LOAD/STREAM/DRAIN, forces IDLE, clears pointers and counters, discards buffered pairs.
REQ-031 Output reset values: in_ready_o=0 during reset, then 1 in the first IDLE cycle after reset; a_o, b_o, last_o, ctrl_o, busy_o, done_o, ovf_o all 0.
REQ-032 Buffer storage is not reset; only its valid count is.

Structure
REQ-033 SYS_ARRAY_SIZE, DRAIN_CHANNEL_SIZE, data_t live in common_pkg; a feeder_state_t enum is added to common_pkg.
REQ-034 The operand buffer is one sub-module, operand_buffer (MAX_K x 2*SYS_ARRAY_SIZE data_t, one write port, one synchronous read port).

Verification (SYS_ARRAY_SIZE=4, MAX_K=16, FLUSH_CYCLES=8, DRAIN_CYCLES=4)
REQ-035 3 pairs A=1,2,3/B=10,20,30, last on 3rd -> three consecutive a_o=1,2,3 with last_o on 3, 8 zero cycles, ctrl_o high 4 cycles, done_o on 4th.
REQ-036 Single pair with in_last_i=1 -> one STREAM cycle with last_o=1, then flush/drain as above.
REQ-037 17 pairs, no last -> 16 accepted, ovf_o pulses on 16th, 16 streamed with last_o on 16th, 17th held by backpressure and accepted after done_o.
REQ-038 in_valid_i toggled randomly during LOAD -> streamed order/values match accepted order exactly, no bubbles in STREAM.
REQ-039 rst_i asserted in 3rd STREAM cycle -> next cycle all outputs zero, busy_o=0; new 2-pair tile then completes normally.
REQ-040 in_valid_i held during DRAIN -> in_ready_o=0 until IDLE; pair accepted first IDLE cycle.
